// File: rtl/i2s_master_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : i2s_master_tx                                               |
// | Wishbone-fed I2S master transmitter with a 32-bit stereo TX FIFO.    |
// | Option : `define I2S_TX_FRAME_CNT_EN adds a frame counter at 0xC.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module i2s_master_tx #(
  parameter int FIFO_ADDR_W = 4,
  parameter int TX_THRESH   = 4
) (
  input  logic        WB_CLK,
  input  logic        WB_RST,
  input  logic [3:0]  WBs_ADR,
  input  logic        WBs_CYC,
  input  logic        WBs_STB,
  input  logic        WBs_WE,
  input  logic [31:0] WBs_WR_DAT,
  output logic [31:0] WBs_RD_DAT,
  output logic        WBs_ACK,
  output logic        I2S_CLK_o,
  output logic        I2S_WS_CLK_o,
  output logic        I2S_DOUT_o,
  output logic        I2S_TX_Intr_o
);

  localparam int                   c_DEPTH    = 1 << FIFO_ADDR_W;
  localparam logic [FIFO_ADDR_W:0] c_FULL_LVL = (FIFO_ADDR_W+1)'(c_DEPTH);
  localparam logic [FIFO_ADDR_W:0] c_THR_LVL  = (FIFO_ADDR_W+1)'(TX_THRESH);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_LAST = 2'd2;

  localparam logic [1:0] c_REG_CTRL  = 2'd0;
  localparam logic [1:0] c_REG_STAT  = 2'd1;
  localparam logic [1:0] c_REG_DATA  = 2'd2;
  localparam logic [1:0] c_REG_FRAME = 2'd3;

  logic                   r_ack;
  logic [31:0]            r_rd_dat;
  logic                   r_en;
  logic [7:0]             r_div;
  logic                   r_underrun;
  logic                   r_overflow;
  logic                   r_intr;

  logic [31:0]            r_mem [c_DEPTH];
  logic [FIFO_ADDR_W-1:0] r_wr_ptr;
  logic [FIFO_ADDR_W-1:0] r_rd_ptr;
  logic [FIFO_ADDR_W:0]   r_level;

  logic [1:0]             r_state;
  logic [7:0]             r_div_act;
  logic [7:0]             r_div_cnt;
  logic                   r_sclk;
  logic                   r_ws;
  logic                   r_dout;
  logic [4:0]             r_n;
  logic [31:0]            r_word;

`ifdef I2S_TX_FRAME_CNT_EN
  logic [15:0]            r_frame_cnt;
`endif

  logic        w_acc, w_wr, w_rd;
  logic [1:0]  w_sel;
  logic        w_push_req, w_push, w_pop, w_ovf_set, w_und_set;
  logic        w_full, w_empty;
  logic        w_tick, w_fall, w_load;
  logic [31:0] w_load_word;
  logic [31:0] w_rd_mux;
  logic        w_unused_adr;

  assign w_acc      = WBs_CYC & WBs_STB & ~r_ack;
  assign w_wr       = w_acc & WBs_WE;
  assign w_rd       = w_acc & ~WBs_WE;
  assign w_sel      = WBs_ADR[3:2];
  assign w_unused_adr = &{1'b0, WBs_ADR[1:0]};

  assign w_full     = (r_level == c_FULL_LVL);
  assign w_empty    = (r_level == '0);
  assign w_push_req = w_wr & (w_sel == c_REG_DATA);
  assign w_push     = w_push_req & ~w_full;
  assign w_ovf_set  = w_push_req & w_full;

  // A frame load happens on leaving IDLE and at every n=31 boundary while enabled.
  assign w_tick = (r_state != c_ST_IDLE) & (r_div_cnt == r_div_act);
  assign w_fall = w_tick & r_sclk;
  assign w_load = r_en & (((r_state == c_ST_IDLE)) |
                          ((r_state == c_ST_RUN) & w_fall & (r_n == 5'd31)));
  assign w_pop       = w_load & ~w_empty;
  assign w_und_set   = w_load & w_empty;
  assign w_load_word = w_empty ? 32'h0 : r_mem[r_rd_ptr];

  always_comb begin
    w_rd_mux = '0;
    case (w_sel)
      c_REG_CTRL: w_rd_mux = {16'h0, r_div, 7'h0, r_en};
      c_REG_STAT: begin
        w_rd_mux[FIFO_ADDR_W:0] = r_level;
        w_rd_mux[8]             = r_underrun;
        w_rd_mux[9]             = r_overflow;
      end
`ifdef I2S_TX_FRAME_CNT_EN
      c_REG_FRAME: w_rd_mux = {16'h0, r_frame_cnt};
`endif
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      r_ack      <= 1'b0;
      r_rd_dat   <= '0;
      r_en       <= 1'b0;
      r_div      <= '0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
      r_intr     <= 1'b0;
    end else begin
      r_ack    <= w_acc;
      r_rd_dat <= w_rd ? w_rd_mux : 32'h0;
      if (w_wr && (w_sel == c_REG_CTRL)) begin
        r_en  <= WBs_WR_DAT[0];
        r_div <= WBs_WR_DAT[15:8];
      end
      // Set terms are OR-ed last so a same-cycle event beats the clear.
      r_underrun <= w_und_set |
                    (r_underrun & ~(w_wr & (w_sel == c_REG_STAT) & WBs_WR_DAT[8]));
      r_overflow <= w_ovf_set |
                    (r_overflow & ~(w_wr & (w_sel == c_REG_STAT) & WBs_WR_DAT[9]));
      r_intr     <= r_en & (r_level <= c_THR_LVL);
    end
  end

`ifdef I2S_TX_FRAME_CNT_EN
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      r_frame_cnt <= '0;
    end else if (w_wr && (w_sel == c_REG_FRAME)) begin
      r_frame_cnt <= '0;
    end else if (w_load) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge WB_CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= WBs_WR_DAT;
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      r_state   <= c_ST_IDLE;
      r_div_act <= '0;
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
      r_ws      <= 1'b0;
      r_dout    <= 1'b0;
      r_n       <= '0;
      r_word    <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_div_cnt <= '0;
          r_sclk    <= 1'b0;
          r_ws      <= 1'b0;
          r_dout    <= 1'b0;
          r_n       <= '0;
          if (r_en) begin
            r_state   <= c_ST_RUN;
            r_div_act <= r_div;
            r_word    <= w_load_word;
          end
        end
        c_ST_RUN, c_ST_LAST: begin
          if (w_tick) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
          if (w_fall) begin
            if (r_state == c_ST_LAST) begin
              r_state <= c_ST_IDLE;
              r_ws    <= 1'b0;
              r_dout  <= 1'b0;
            end else if (r_n == 5'd31) begin
              // Period 0 carries the previous word's LSB (one-bit I2S delay).
              r_n    <= '0;
              r_ws   <= 1'b0;
              r_dout <= r_word[0];
              if (r_en) begin
                r_word    <= w_load_word;
                r_div_act <= r_div;
              end else begin
                r_state <= c_ST_LAST;
              end
            end else begin
              r_n    <= r_n + 5'd1;
              r_dout <= r_word[5'd31 - r_n];
              r_ws   <= (r_n >= 5'd15);
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign WBs_ACK       = r_ack;
  assign WBs_RD_DAT    = r_rd_dat;
  assign I2S_CLK_o     = r_sclk;
  assign I2S_WS_CLK_o  = r_ws;
  assign I2S_DOUT_o    = r_dout;
  assign I2S_TX_Intr_o = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_i2s_master_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_i2s_master_tx                                            |
// | Directed bench: register vector table plus serial-frame sequences.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_i2s_master_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  adr = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        ack;
  logic        sclk, ws, dout, intr;

  int tests = 0;
  int fails = 0;

  i2s_master_tx #(.FIFO_ADDR_W(4), .TX_THRESH(4)) dut (
    .WB_CLK        (clk),
    .WB_RST        (rst),
    .WBs_ADR       (adr),
    .WBs_CYC       (cyc),
    .WBs_STB       (stb),
    .WBs_WE        (we),
    .WBs_WR_DAT    (wdat),
    .WBs_RD_DAT    (rdat),
    .WBs_ACK       (ack),
    .I2S_CLK_o     (sclk),
    .I2S_WS_CLK_o  (ws),
    .I2S_DOUT_o    (dout),
    .I2S_TX_Intr_o (intr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receiver model: capture DOUT/WS at every SCLK rising edge.
  logic cap_d  [2048];
  logic cap_ws [2048];
  int   cap_t  [2048];
  int   edges   = 0;
  int   cyc_cnt = 0;
  logic prev_sclk = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc_cnt = cyc_cnt + 1;
    if (sclk && !prev_sclk) begin
      cap_d[edges & 2047]  = dout;
      cap_ws[edges & 2047] = ws;
      cap_t[edges & 2047]  = cyc_cnt;
      edges = edges + 1;
    end
    prev_sclk = sclk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic wb(input logic w, input logic [3:0] a, input logic [31:0] d,
                    output logic [31:0] r);
    int k;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ack && k < 4);
    if (!ack) begin
      tests++; fails++;
      $display("FAIL wb_ack: got 0, expected 1 at address 0x%0h", a);
    end
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_edges(input int base, input int target, input int budget, input string name);
    int k;
    k = 0;
    while ((edges - base) < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if ((edges - base) < target) begin
      tests++; fails++;
      $display("FAIL %s: got %0d SCLK edges, expected %0d", name, edges - base, target);
    end
  endtask

  function automatic logic [31:0] grab(input int start, input int n, input bit sel_ws);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < n; j++)
      v = {v[30:0], sel_ws ? cap_ws[(start + j) & 2047] : cap_d[(start + j) & 2047]};
    return v;
  endfunction

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b ^ 8'hA0, ~b, b + 8'h5A};
  endfunction

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] r;
    int base, bad;
    logic [31:0] exp_frame;

    vecs[0]  = '{1'b0, 4'h4, 32'h0,         32'h0000_0000};
    vecs[1]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0000};
    vecs[2]  = '{1'b0, 4'hC, 32'h0,         32'h0000_0000};
    vecs[3]  = '{1'b1, 4'h0, 32'hFFFF_FFFE, 32'h0};
    vecs[4]  = '{1'b0, 4'h0, 32'h0,         32'h0000_FF00};
    vecs[5]  = '{1'b0, 4'h8, 32'h0,         32'h0000_0000};
    vecs[6]  = '{1'b1, 4'h8, 32'h1234_5678, 32'h0};
    vecs[7]  = '{1'b1, 4'h8, 32'h9ABC_DEF0, 32'h0};
    vecs[8]  = '{1'b0, 4'h4, 32'h0,         32'h0000_0002};
    vecs[9]  = '{1'b1, 4'h4, 32'h0000_0300, 32'h0};
    vecs[10] = '{1'b0, 4'h4, 32'h0,         32'h0000_0002};
    vecs[11] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0};
    vecs[12] = '{1'b0, 4'h0, 32'h0,         32'h0000_0000};

    // Reset state
    do_reset();
    check("reset_outputs", {27'h0, sclk, ws, dout, ack, intr}, 32'h0);
    wb(1'b0, 4'h4, 32'h0, r);
    check("reset_status", r, 32'h0);

    // Register vectors
    for (int i = 0; i < 13; i++) begin
      wb(vecs[i].w, vecs[i].a, vecs[i].d, r);
      if (!vecs[i].w) check($sformatf("vec%0d", i), r, vecs[i].exp);
    end
    check("idle_outputs", {29'h0, sclk, ws, dout}, 32'h0);

    // Single frame at DIV=1, EN cleared at n=10
    do_reset();
    wb(1'b1, 4'h0, 32'h0000_0100, r);
    wb(1'b1, 4'h8, 32'hA5A5_3C3C, r);
    base = edges;
    wb(1'b1, 4'h0, 32'h0000_0101, r);
    wait_edges(base, 11, 200, "frame_n10");
    wb(1'b1, 4'h0, 32'h0000_0100, r);
    repeat (200) @(negedge clk);
    check("frame_edge_count", 32'(edges - base), 32'd33);
    check("frame_bit0_dout", {31'h0, cap_d[base & 2047]}, 32'h0);
    check("frame_left", grab(base + 1, 16, 1'b0), 32'h0000_A5A5);
    check("frame_right", grab(base + 17, 16, 1'b0), 32'h0000_3C3C);
    check("frame_ws", grab(base, 32, 1'b1), 32'h0000_FFFF);
    check("final_ws", {31'h0, cap_ws[(base + 32) & 2047]}, 32'h0);
    check("frame_cycles", 32'(cap_t[(base + 32) & 2047] - cap_t[base & 2047]), 32'd128);
    check("post_idle_outputs", {29'h0, sclk, ws, dout}, 32'h0);
`ifdef I2S_TX_FRAME_CNT_EN
    exp_frame = 32'd1;
`else
    exp_frame = 32'd0;
`endif
    wb(1'b0, 4'hC, 32'h0, r);
    check("frame_counter", r, exp_frame);
    wb(1'b0, 4'h4, 32'h0, r);
    check("frame_status", r, 32'h0);

    // Underrun
    do_reset();
    base = edges;
    wb(1'b1, 4'h0, 32'h0000_0101, r);
    wait_edges(base, 32, 400, "underrun_frame");
    check("underrun_dout", grab(base, 32, 1'b0), 32'h0);
    wb(1'b1, 4'h0, 32'h0000_0100, r);
    repeat (200) @(negedge clk);
    wb(1'b0, 4'h4, 32'h0, r);
    check("underrun_flag", r, 32'h0000_0100);
    wb(1'b1, 4'h4, 32'h0000_0100, r);
    wb(1'b0, 4'h4, 32'h0, r);
    check("underrun_clear", r, 32'h0);

    // Overflow: 17 pushes, 17th must never be transmitted
    do_reset();
    for (int i = 0; i < 17; i++) wb(1'b1, 4'h8, word_of(i), r);
    wb(1'b0, 4'h4, 32'h0, r);
    check("overflow_status", r, 32'h0000_0210);
    base = edges;
    wb(1'b1, 4'h0, 32'h0000_0001, r);
    wait_edges(base, 546, 3000, "overflow_stream");
    wb(1'b1, 4'h0, 32'h0000_0000, r);
    repeat (200) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (grab(base + 32 * k + 1, 32, 1'b0) !== word_of(k)) bad++;
    check("overflow_words_bad", 32'(bad), 32'h0);
    check("overflow_17th_absent", grab(base + 32 * 16 + 1, 32, 1'b0), 32'h0);
    wb(1'b0, 4'h4, 32'h0, r);
    check("overflow_end_status", r, 32'h0000_0300);

    // Interrupt threshold and reset mid-frame
    do_reset();
    for (int i = 0; i < 6; i++) wb(1'b1, 4'h8, word_of(i + 40), r);
    check("intr_disabled", {31'h0, intr}, 32'h0);
    base = edges;
    wb(1'b1, 4'h0, 32'h0000_0001, r);
    wait_edges(base, 31, 200, "intr_frame0");
    check("intr_after_load1", {31'h0, intr}, 32'h0);
    wait_edges(base, 34, 200, "intr_frame1");
    check("intr_after_load2", {31'h0, intr}, 32'h1);
    wb(1'b1, 4'h8, 32'hDEAD_BEEF, r);
    @(negedge clk);
    check("intr_after_push", {31'h0, intr}, 32'h0);
    do_reset();
    check("midframe_reset", {27'h0, sclk, ws, dout, ack, intr}, 32'h0);
    repeat (20) @(negedge clk);
    check("midframe_reset_hold", {28'h0, sclk, ws, dout, intr}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
